ro_puf_ctrl: RTL and testbench

Sequencer for the ring-oscillator PUF datapath. It takes a start request with an 8-bit base challenge and drives the oscillator enable, challenge select and counter clear/gate for `N_BITS` consecutive challenges. For each challenge it compares the two captured counts and packs the results into an `N_BITS`-bit response word. The word, with a per-bit reliability mask, is returned over a valid/ready handshake to the key/ID logic.

---
 rtl/ro_puf_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ro_puf_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF sequencer: steps N_BITS challenges through settle/count/sample,
// packs one comparison bit per challenge and hands the word out over valid/ready.
module ro_puf_ctrl #(
   parameter int N_BITS     = 16,
   parameter int SETTLE_CYC = 4,
   parameter int WINDOW_CYC = 1024,
   parameter int CW         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        base_chal,
   input  logic              abort,
   input  logic [CW-1:0]     cnt_a,
   input  logic [CW-1:0]     cnt_b,
   output logic              ro_en,
   output logic [7:0]        challenge,
   output logic              cnt_clr,
   output logic              cnt_en,
   output logic              busy,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [N_BITS-1:0] resp,
   output logic [N_BITS-1:0] unrel
);

   localparam int IW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam int TMAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST    = IW'(N_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_COUNT,
      S_SAMPLE,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [7:0]        chal_q, chal_d;
   logic [N_BITS-1:0] resp_q, resp_d;
   logic [N_BITS-1:0] unrel_q, unrel_d;

   logic ro_en_q, ro_en_d;
   logic cnt_clr_q, cnt_clr_d;
   logic cnt_en_q, cnt_en_d;
   logic busy_q, busy_d;
   logic valid_q, valid_d;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      chal_d  = chal_q;
      resp_d  = resp_q;
      unrel_d = unrel_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_SETTLE;
               chal_d  = base_chal;
               idx_d   = '0;
               tmr_d   = '0;
               resp_d  = '0;
               unrel_d = '0;
            end
         end
         S_SETTLE: begin
            if (tmr_q == SETTLE_LAST) begin
               tmr_d   = '0;
               state_d = S_COUNT;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_COUNT: begin
            if (tmr_q == WINDOW_LAST) begin
               tmr_d   = '0;
               state_d = S_SAMPLE;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_SAMPLE: begin
            resp_d[idx_q]  = (cnt_b >= cnt_a);
            unrel_d[idx_q] = (cnt_a == cnt_b) || (cnt_a == '1) || (cnt_b == '1);
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IW'(1);
               chal_d  = chal_q + 8'd1;
               tmr_d   = '0;
               state_d = S_SETTLE;
            end
         end
         S_DONE: begin
            // Abort here simply drops the word, exactly like a completed handshake.
            if (resp_ready || abort) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A cancelled evaluation must not leave a partial word behind.
      if (abort && (state_q == S_SETTLE || state_q == S_COUNT || state_q == S_SAMPLE)) begin
         state_d = S_IDLE;
         tmr_d   = '0;
         resp_d  = '0;
         unrel_d = '0;
      end
   end

   // Output flops are loaded from the next state so every output is a plain register.
   always_comb begin
      ro_en_d   = (state_d == S_SETTLE) || (state_d == S_COUNT) || (state_d == S_SAMPLE);
      cnt_clr_d = (state_d == S_IDLE) || (state_d == S_SETTLE) || (state_d == S_DONE);
      cnt_en_d  = (state_d == S_COUNT);
      busy_d    = (state_d != S_IDLE);
      valid_d   = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         tmr_q     <= '0;
         idx_q     <= '0;
         chal_q    <= '0;
         resp_q    <= '0;
         unrel_q   <= '0;
         ro_en_q   <= 1'b0;
         cnt_clr_q <= 1'b1;
         cnt_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         idx_q     <= idx_d;
         chal_q    <= chal_d;
         resp_q    <= resp_d;
         unrel_q   <= unrel_d;
         ro_en_q   <= ro_en_d;
         cnt_clr_q <= cnt_clr_d;
         cnt_en_q  <= cnt_en_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
      end
   end

   assign ro_en      = ro_en_q;
   assign challenge  = chal_q;
   assign cnt_clr    = cnt_clr_q;
   assign cnt_en     = cnt_en_q;
   assign busy       = busy_q;
   assign resp_valid = valid_q;
   assign resp       = resp_q;
   assign unrel      = unrel_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Directed bench for ro_puf_ctrl with a per-challenge counter model (k counts per gated cycle,
// saturating at all-ones); expected words and timings are hand-computed.
module tb_ro_puf_ctrl;

   localparam int N_BITS     = 4;
   localparam int SETTLE_CYC = 2;
   localparam int WINDOW_CYC = 8;
   localparam int CW         = 8;
   localparam int P          = SETTLE_CYC + WINDOW_CYC + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    base_chal;
   logic          abort;
   logic [CW-1:0] cnt_a;
   logic [CW-1:0] cnt_b;
   logic          ro_en;
   logic [7:0]    challenge;
   logic          cnt_clr;
   logic          cnt_en;
   logic          busy;
   logic          resp_valid;
   logic          resp_ready;
   logic [N_BITS-1:0] resp;
   logic [N_BITS-1:0] unrel;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] rate_a [256];
   logic [7:0] rate_b [256];
   logic [7:0] ca = '0;
   logic [7:0] cb = '0;

   ro_puf_ctrl #(
      .N_BITS    (N_BITS),
      .SETTLE_CYC(SETTLE_CYC),
      .WINDOW_CYC(WINDOW_CYC),
      .CW        (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_chal (base_chal),
      .abort     (abort),
      .cnt_a     (cnt_a),
      .cnt_b     (cnt_b),
      .ro_en     (ro_en),
      .challenge (challenge),
      .cnt_clr   (cnt_clr),
      .cnt_en    (cnt_en),
      .busy      (busy),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp      (resp),
      .unrel     (unrel)
   );

   always #5 clk = ~clk;

   // Counter pair model: cleared by cnt_clr, adds the challenge's rate per gated cycle.
   always @(posedge clk) begin
      int sa, sb;
      sa = int'(ca) + int'(rate_a[challenge]);
      sb = int'(cb) + int'(rate_b[challenge]);
      if (cnt_clr === 1'b1) begin
         ca <= '0;
         cb <= '0;
      end else if (cnt_en === 1'b1) begin
         ca <= (sa > 255) ? 8'hFF : 8'(sa);
         cb <= (sb > 255) ? 8'hFF : 8'(sb);
      end
   end

   assign cnt_a = ca;
   assign cnt_b = cb;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_rate(input logic [7:0] chal, input logic [7:0] ka, input logic [7:0] kb);
      rate_a[chal] = ka;
      rate_b[chal] = kb;
   endtask

   // Runs one evaluation and stops in the first DONE cycle with resp_ready low.
   task automatic run_eval(input string name, input logic [7:0] base, input logic [31:0] exp_chals,
                           input logic [3:0] exp_resp, input logic [3:0] exp_unrel);
      int n;
      int en_cnt [N_BITS];
      logic [7:0] ec;
      for (int i = 0; i < N_BITS; i++) en_cnt[i] = 0;
      start     = 1'b1;
      base_chal = base;
      tick();
      start     = 1'b0;
      check({name, "_busy_at_start"}, busy, 1);
      n = 0;
      while (!resp_valid && n < 200) begin
         if ((n % P) == 0 && n < N_BITS * P) begin
            ec = exp_chals[8*(n/P) +: 8];
            check($sformatf("%s_chal%0d", name, n / P), challenge, ec);
         end
         if (cnt_en && n < N_BITS * P) en_cnt[n / P]++;
         tick();
         n++;
      end
      check({name, "_valid_latency"}, n, N_BITS * P);
      for (int i = 0; i < N_BITS; i++)
         check($sformatf("%s_en_cycles%0d", name, i), en_cnt[i], WINDOW_CYC);
      check({name, "_resp"}, resp, exp_resp);
      check({name, "_unrel"}, unrel, exp_unrel);
      check({name, "_done_ro_en"}, ro_en, 0);
      check({name, "_done_cnt_clr"}, cnt_clr, 1);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ro_en"}, ro_en, 0);
      check({name, "_challenge"}, challenge, 0);
      check({name, "_cnt_clr"}, cnt_clr, 1);
      check({name, "_cnt_en"}, cnt_en, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_resp_valid"}, resp_valid, 0);
      check({name, "_resp"}, resp, 0);
      check({name, "_unrel"}, unrel, 0);
   endtask

   initial begin
      for (int c = 0; c < 256; c++) begin
         rate_a[c] = 8'd1;
         rate_b[c] = 8'd1;
      end
      rst        = 1'b1;
      start      = 1'b0;
      base_chal  = 8'h00;
      abort      = 1'b0;
      resp_ready = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();
      check("idle_busy", busy, 0);

      // Nominal: A>B on bits 0 and 2, B>A on bits 1 and 3.
      set_rate(8'h3E, 8'd5, 8'd3);
      set_rate(8'h3F, 8'd2, 8'd6);
      set_rate(8'h40, 8'd7, 8'd1);
      set_rate(8'h41, 8'd3, 8'd4);
      run_eval("nominal", 8'h3E, 32'h41403F3E, 4'b1010, 4'b0000);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("nominal_accept_valid", resp_valid, 0);
      check("nominal_accept_busy", busy, 0);
      check("nominal_resp_held", resp, 4'b1010);

      // Tie on bit 1, saturated cnt_a on bit 3, then backpressure in DONE.
      set_rate(8'h10, 8'd5, 8'd3);
      set_rate(8'h11, 8'd4, 8'd4);
      set_rate(8'h12, 8'd1, 8'd2);
      set_rate(8'h13, 8'd40, 8'd3);
      run_eval("tie_sat", 8'h10, 32'h13121110, 4'b0110, 4'b1010);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            start     = 1'b1;
            base_chal = 8'h55;
         end
         if (i == 6) start = 1'b0;
         tick();
         check($sformatf("bp_valid%0d", i), resp_valid, 1);
         check($sformatf("bp_resp%0d", i), resp, 4'b0110);
      end
      check("bp_unrel", unrel, 4'b1010);
      check("bp_chal", challenge, 8'h13);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("bp_idle_busy", busy, 0);
      check("bp_idle_valid", resp_valid, 0);
      tick();
      check("bp_start_ignored", busy, 0);

      // Abort wins over start in IDLE.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("idle_abort_prio", busy, 0);

      // Abort during COUNT of bit 2.
      start     = 1'b1;
      base_chal = 8'h3E;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2 * P + SETTLE_CYC + 3; i++) tick();
      check("abort_in_count", cnt_en, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_ro_en", ro_en, 0);
      check("abort_cnt_clr", cnt_clr, 1);
      check("abort_resp", resp, 0);
      check("abort_unrel", unrel, 0);
      begin
         int seen = 0;
         for (int i = 0; i < 60; i++) begin
            if (resp_valid) seen++;
            tick();
         end
         check("abort_no_valid", seen, 0);
      end

      // Challenge wrap, straight after the aborted run.
      run_eval("wrap", 8'hFE, 32'h0100FFFE, 4'b1111, 4'b1111);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("wrap_accept_busy", busy, 0);

      // Reset in SETTLE of bit 1.
      start     = 1'b1;
      base_chal = 8'h3F;
      tick();
      start = 1'b0;
      for (int i = 0; i < P; i++) tick();
      check("rst_pre_chal", challenge, 8'h40);
      check("rst_pre_resp", resp, 4'b0001);
      check("rst_pre_cnt_clr", cnt_clr, 1);
      rst        = 1'b1;
      start      = 1'b1;
      resp_ready = 1'b1;
      tick();
      rst        = 1'b0;
      start      = 1'b0;
      resp_ready = 1'b0;
      check_reset_outputs("midrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
